// File: rtl/branch_predictor_pkg.sv
// Shared CPU package for the fetch-stage branch predictor.
// Holds the 2-bit saturating counter encodings and the default table depth.
package branch_predictor_pkg;

  localparam int unsigned BP_ENTRIES_DEF = 16;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,  // strongly not-taken
    CNT_WNT = 2'b01,  // weakly not-taken
    CNT_WT  = 2'b10,  // weakly taken
    CNT_ST  = 2'b11   // strongly taken
  } cnt_state_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating counter.
// Ports:
//   cnt_i  - current counter value
//   inc_i  - 1: count up toward ST, 0: count down toward SNT
//   cnt_o  - next counter value, saturating at ST/SNT
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is purely combinational from pc_i and registered table state; updates
// from the resolve stage land on the next rising edge (no same-cycle bypass).
// Ports:
//   clk_i, rst_i           - clock, async active-low reset
//   pc_i                   - fetch PC to look up
//   next_pc_o              - predicted next fetch PC
//   pred_taken_o           - hit and counter predicts taken
//   upd_valid_i/pc/taken/target/mispred - resolved branch update
//   mispred_cnt_o          - saturating misprediction count
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES_DEF,
  parameter int ADDR_W  = 32,
  parameter int MODE    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              pred_taken_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispred_i,
  output logic [15:0]       mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         cnt_q    [ENTRIES];
  logic [1:0]         cnt_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [15:0]        mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  logic [1:0]       upd_cnt_nxt;
  logic             upd_pc_unused;

  // Instructions are word aligned; the low PC bits carry no index/tag info.
  assign upd_pc_unused = ^upd_pc_i[1:0];

  assign lk_idx  = pc_i[IDX_W+1:2];
  assign lk_tag  = pc_i[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];

  assign lk_hit  = valid_q[lk_idx]  && (tag_q[lk_idx]  == lk_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  sat_counter2 u_sat_counter2 (
    .cnt_i (cnt_q[upd_idx]),
    .inc_i (upd_taken_i),
    .cnt_o (upd_cnt_nxt)
  );

  always_comb begin
    pred_taken_o = (MODE == 1) && lk_hit && cnt_q[lk_idx][1];
    next_pc_o    = pred_taken_o ? target_q[lk_idx] : pc_i + ADDR_W'(4);
  end

  always_comb begin
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd_valid_i) begin
      if (upd_hit) begin
        cnt_d[upd_idx] = upd_cnt_nxt;
        if (upd_taken_i) target_d[upd_idx] = upd_target_i;
      end else if (upd_taken_i) begin
        // Taken miss evicts whatever occupies the slot.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target_i;
        cnt_d[upd_idx]    = CNT_WT;
      end
    end
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid_i && upd_mispred_i && (mispred_cnt_q != 16'hFFFF))
      mispred_cnt_d = mispred_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q       <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
    end else begin
      valid_q       <= valid_d;
      mispred_cnt_q <= mispred_cnt_d;
      cnt_q         <= cnt_d;
    end
  end

  // Tag/target are qualified by valid, so they need no reset.
  always_ff @(posedge clk_i) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_mispred_i;

  logic [31:0] d1_npc, d0_npc;
  logic        d1_pred, d0_pred;
  logic [15:0] d1_cnt, d0_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    int          which;  // 1: MODE=1 instance, 0: MODE=0 instance
    int          kind;   // 0 pred_taken, 1 next_pc, 2 mispred_cnt
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  branch_predictor #(.ENTRIES(16), .ADDR_W(32), .MODE(1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .next_pc_o(d1_npc),
    .pred_taken_o(d1_pred), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .upd_mispred_i(upd_mispred_i), .mispred_cnt_o(d1_cnt)
  );

  branch_predictor #(.ENTRIES(16), .ADDR_W(32), .MODE(0)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .next_pc_o(d0_npc),
    .pred_taken_o(d0_pred), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .upd_mispred_i(upd_mispred_i), .mispred_cnt_o(d0_cnt)
  );

  // Monitor: outputs are stable mid-cycle; compare every queued expectation.
  always @(negedge clk_i) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        0:       act = {31'd0, (e.which == 1) ? d1_pred : d0_pred};
        1:       act = (e.which == 1) ? d1_npc : d0_npc;
        default: act = {16'd0, (e.which == 1) ? d1_cnt : d0_cnt};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s (dut MODE=%0d kind=%0d): got 0x%08h expected 0x%08h",
                 e.name, e.which, e.kind, act, e.val);
      end
    end
  end

  task automatic cyc(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                     input logic ut, input logic [31:0] utgt, input logic um);
    @(posedge clk_i);
    #1;
    pc_i = pc; upd_valid_i = uv; upd_pc_i = upc;
    upd_taken_i = ut; upd_target_i = utgt; upd_mispred_i = um;
  endtask

  task automatic idle(input logic [31:0] pc);
    cyc(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic exp_pred(input string n, input int w, input logic p, input logic [31:0] npc);
    sb.push_back('{name: n, which: w, kind: 0, val: {31'd0, p}});
    sb.push_back('{name: n, which: w, kind: 1, val: npc});
  endtask

  task automatic exp_cnt(input string n, input logic [15:0] c);
    sb.push_back('{name: n, which: 1, kind: 2, val: {16'd0, c}});
    sb.push_back('{name: n, which: 0, kind: 2, val: {16'd0, c}});
  endtask

  initial begin
    rst_i = 1'b0;
    pc_i = 32'h40; upd_valid_i = 1'b0; upd_pc_i = '0;
    upd_taken_i = 1'b0; upd_target_i = '0; upd_mispred_i = 1'b0;

    idle(32'h40);
    exp_cnt("in_reset_cnt", 16'd0);
    exp_pred("in_reset_pred", 1, 1'b0, 32'h44);
    idle(32'h40);
    rst_i = 1'b1;

    idle(32'h40);
    exp_pred("after_reset", 1, 1'b0, 32'h44);
    exp_pred("after_reset_m0", 0, 1'b0, 32'h44);
    exp_cnt("after_reset_cnt", 16'd0);

    // first taken allocate with same-cycle lookup
    cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    exp_pred("collision_same_cycle", 1, 1'b0, 32'h44);
    exp_pred("collision_m0", 0, 1'b0, 32'h44);
    // counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11
    cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    exp_pred("alloc_hit", 1, 1'b1, 32'h100);
    exp_pred("alloc_m0", 0, 1'b0, 32'h44);
    cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    exp_pred("cnt_01", 1, 1'b0, 32'h44);
    cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    exp_pred("cnt_00", 1, 1'b0, 32'h44);
    cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    exp_pred("cnt_00_held", 1, 1'b0, 32'h44);
    cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    exp_pred("cnt_01_up", 1, 1'b0, 32'h44);
    cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0);
    exp_pred("cnt_10_up", 1, 1'b1, 32'h100);
    idle(32'h40);
    exp_pred("target_rewrite", 1, 1'b1, 32'h200);

    // not-taken miss and upd_valid=0 leave the table alone
    cyc(32'h48, 1'b1, 32'h48, 1'b0, 32'h0, 1'b0);
    exp_pred("nt_miss_before", 1, 1'b0, 32'h4C);
    cyc(32'h48, 1'b0, 32'h48, 1'b1, 32'h600, 1'b1);
    exp_pred("nt_miss_no_alloc", 1, 1'b0, 32'h4C);
    idle(32'h48);
    exp_pred("upd_invalid_ignored", 1, 1'b0, 32'h4C);
    exp_cnt("upd_invalid_no_cnt", 16'd0);

    // aliasing: 0x80 shares index 0 with 0x40
    cyc(32'h40, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0);
    exp_pred("alias_pre", 1, 1'b1, 32'h200);
    idle(32'h40);
    exp_pred("alias_evicted", 1, 1'b0, 32'h44);
    cyc(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0);
    exp_pred("alias_new_hit", 1, 1'b1, 32'h300);
    cyc(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0);
    exp_pred("cnt_11", 1, 1'b1, 32'h300);
    cyc(32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    exp_pred("cnt_11_held", 1, 1'b1, 32'h300);
    idle(32'h80);
    exp_pred("cnt_11_dec_10", 1, 1'b1, 32'h300);

    idle(32'hFFFF_FFFC);
    exp_pred("pc_wrap", 1, 1'b0, 32'h0);
    exp_pred("pc_wrap_m0", 0, 1'b0, 32'h0);

    // misprediction counter
    for (int i = 0; i < 3; i++) cyc(32'h80, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b1);
    cyc(32'h80, 1'b0, 32'h1000, 1'b0, 32'h0, 1'b1);
    exp_cnt("mispred_3", 16'd3);
    idle(32'h80);
    exp_cnt("mispred_gated", 16'd3);
    exp_pred("nt_miss_kept_entry", 1, 1'b1, 32'h300);
    for (int i = 0; i < 65531; i++) cyc(32'h80, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b1);
    idle(32'h80);
    exp_cnt("mispred_fffe", 16'hFFFE);
    for (int i = 0; i < 6; i++) cyc(32'h80, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b1);
    idle(32'h80);
    exp_cnt("mispred_sat", 16'hFFFF);

    // reset asserted in the middle of an update
    cyc(32'h80, 1'b1, 32'h44, 1'b1, 32'h500, 1'b1);
    #2 rst_i = 1'b0;
    exp_cnt("mid_reset_cnt", 16'd0);
    exp_pred("mid_reset_pred", 1, 1'b0, 32'h84);
    idle(32'h80);
    rst_i = 1'b1;
    idle(32'h44);
    exp_pred("reset_update_discarded", 1, 1'b0, 32'h48);
    cyc(32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    exp_pred("cold_pre", 1, 1'b0, 32'h84);
    cyc(32'h80, 1'b1, 32'h80, 1'b1, 32'h700, 1'b0);
    exp_pred("cold_nt_miss", 1, 1'b0, 32'h84);
    idle(32'h80);
    exp_pred("cold_alloc", 1, 1'b1, 32'h700);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_i);
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
